icache_fill_ctrl: RTL

- Instruction-cache miss/refill sequencer between the fetch stage-2 lookup, the tag banks and the data banks.
- On a stage-2 miss it stalls fetch and picks a victim way by round-robin.
- It then requests a line-aligned burst from memory, writes each returned word into the data banks, and commits the new tag for the victim way.
- It also forwards the missed word to fetch as it arrives.

---
 rtl/icache_fill_ctrl_pkg.sv | 9 +
 rtl/icache_fill_ctrl_way_rr_sel.sv | 17 +
 rtl/icache_fill_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/icache_fill_ctrl_pkg.sv
// icache_fill_ctrl_pkg: shared I-cache geometry and refill sequencer states.
package icache_fill_ctrl_pkg;
    localparam int ICACHE_WAYS            = 2;
    localparam int ICACHE_LINES           = 64;
    localparam int ICACHE_WORDS           = 4;
    localparam int ICACHE_LINE_ADDR_W     = $clog2(ICACHE_LINES);
    localparam int ICACHE_SUB_LINE_ADDR_W = $clog2(ICACHE_WORDS);
    typedef enum logic [2:0] {IDLE, REQ, FILL, UPDATE, FLUSH} fill_state_t;
endpackage

// File: rtl/icache_fill_ctrl_way_rr_sel.sv
// icache_fill_ctrl_way_rr_sel: round-robin one-hot victim way pointer.
module icache_fill_ctrl_way_rr_sel #(
    parameter int WAYS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            adv,
    input  logic            clr,
    output logic [WAYS-1:0] way
);
    logic [WAYS-1:0] ptr_q, ptr_d;
    always_comb ptr_d = clr ? WAYS'(1) : adv ? {ptr_q[WAYS-2:0], ptr_q[WAYS-1]} : ptr_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= WAYS'(1);
        else ptr_q <= ptr_d;
    assign way = ptr_q;
endmodule

// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: I-cache miss refill sequencer (round-robin victim, in-order burst, critical-word forward).
// Define ICACHE_FLUSH_EN to add the FENCE.I tag-invalidate walk.
module icache_fill_ctrl
    import icache_fill_ctrl_pkg::*;
#(
    parameter  int WAYS   = ICACHE_WAYS,
    parameter  int LINES  = ICACHE_LINES,
    parameter  int WORDS  = ICACHE_WORDS,
    localparam int LINE_W = $clog2(LINES),
    localparam int SUB_W  = $clog2(WORDS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    miss,
    input  logic [31:0]             miss_addr,
    output logic                    fill_busy,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    input  logic                    mem_ack,
    input  logic                    mem_rvalid,
    input  logic [31:0]             mem_rdata,
    output logic                    data_we,
    output logic [WAYS-1:0]         data_way,
    output logic [LINE_W+SUB_W-1:0] data_addr,
    output logic [31:0]             data_wdata,
    output logic                    tag_update,
    output logic [WAYS-1:0]         tag_update_way,
    output logic [31:0]             fill_addr,
    output logic                    fwd_valid,
    output logic [31:0]             fwd_data,
    input  logic                    flush_req,
    output logic                    flush_done
);
    fill_state_t             state_q, state_d;
    logic [31:0]             fill_addr_q, fill_addr_d, mem_addr_q, mem_addr_d;
    logic [31:0]             data_wdata_q, data_wdata_d, fwd_data_q, fwd_data_d;
    logic [LINE_W+SUB_W-1:0] data_addr_q, data_addr_d;
    logic [WAYS-1:0]         data_way_q, data_way_d, tag_update_way_q, tag_update_way_d, victim;
    logic [SUB_W:0]          cnt_q, cnt_d;
    logic                    fill_busy_q, fill_busy_d, mem_req_q, mem_req_d, data_we_q, data_we_d;
    logic                    tag_update_q, tag_update_d, fwd_valid_q, fwd_valid_d;
    logic                    flush_done_q, flush_done_d;
    logic [LINE_W-1:0]       line;
    logic                    crit, flush_go, flush_clr;

    assign line = fill_addr_q[SUB_W+2 +: LINE_W];
    assign crit = cnt_q[SUB_W-1:0] == fill_addr_q[SUB_W+1:2];

`ifdef ICACHE_FLUSH_EN
    logic flush_pend_q, flush_pend_d;
    assign flush_go  = flush_req | flush_pend_q;
    assign flush_clr = state_q == FLUSH;
`else
    logic unused_flush_req;
    assign unused_flush_req = flush_req;
    assign flush_go         = 1'b0;
    assign flush_clr        = 1'b0;
`endif

    icache_fill_ctrl_way_rr_sel #(.WAYS(WAYS)) u_way_rr_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (state_q == UPDATE),
        .clr   (flush_clr),
        .way   (victim)
    );

    always_comb begin
        state_d          = state_q;
        fill_addr_d      = fill_addr_q;
        mem_addr_d       = mem_addr_q;
        data_wdata_d     = data_wdata_q;
        fwd_data_d       = fwd_data_q;
        data_addr_d      = data_addr_q;
        data_way_d       = data_way_q;
        tag_update_way_d = tag_update_way_q;
        cnt_d            = cnt_q;
        fill_busy_d      = fill_busy_q;
        mem_req_d        = 1'b0;
        data_we_d        = 1'b0;
        tag_update_d     = 1'b0;
        fwd_valid_d      = 1'b0;
        flush_done_d     = 1'b0;
`ifdef ICACHE_FLUSH_EN
        flush_pend_d     = flush_pend_q | (flush_req && state_q != IDLE && state_q != FLUSH);
`endif
        case (state_q)
            IDLE: if (flush_go) begin
                state_d          = FLUSH;
                fill_busy_d      = 1'b1;
                tag_update_d     = 1'b1;
                tag_update_way_d = '1;
                fill_addr_d      = '0;
`ifdef ICACHE_FLUSH_EN
                flush_pend_d     = 1'b0;
`endif
            end else if (miss) begin
                state_d     = REQ;
                fill_addr_d = miss_addr;
                fill_busy_d = 1'b1;
                mem_req_d   = 1'b1;
                mem_addr_d  = {miss_addr[31:SUB_W+2], {(SUB_W+2){1'b0}}};
                cnt_d       = '0;
            end
            REQ: begin
                mem_req_d = !mem_ack;
                state_d   = mem_ack ? FILL : REQ;
            end
            // Tag goes out only after the last data write has been presented.
            FILL: if (cnt_q == (SUB_W+1)'(WORDS)) begin
                state_d          = UPDATE;
                tag_update_d     = 1'b1;
                tag_update_way_d = victim;
            end else if (mem_rvalid) begin
                data_we_d    = 1'b1;
                data_way_d   = victim;
                data_addr_d  = {line, cnt_q[SUB_W-1:0]};
                data_wdata_d = mem_rdata;
                fwd_valid_d  = crit;
                fwd_data_d   = crit ? mem_rdata : fwd_data_q;
                cnt_d        = cnt_q + 1'b1;
            end
            UPDATE: begin
                state_d     = IDLE;
                fill_busy_d = 1'b0;
            end
`ifdef ICACHE_FLUSH_EN
            FLUSH: if (line == LINE_W'(LINES-1)) begin
                state_d      = IDLE;
                fill_busy_d  = 1'b0;
                flush_done_d = 1'b1;
            end else begin
                tag_update_d = 1'b1;
                fill_addr_d  = fill_addr_q + (32'd1 << (SUB_W+2));
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            fill_addr_q      <= '0;
            mem_addr_q       <= '0;
            data_wdata_q     <= '0;
            fwd_data_q       <= '0;
            data_addr_q      <= '0;
            data_way_q       <= '0;
            tag_update_way_q <= '0;
            cnt_q            <= '0;
            fill_busy_q      <= 1'b0;
            mem_req_q        <= 1'b0;
            data_we_q        <= 1'b0;
            tag_update_q     <= 1'b0;
            fwd_valid_q      <= 1'b0;
            flush_done_q     <= 1'b0;
`ifdef ICACHE_FLUSH_EN
            flush_pend_q     <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            fill_addr_q      <= fill_addr_d;
            mem_addr_q       <= mem_addr_d;
            data_wdata_q     <= data_wdata_d;
            fwd_data_q       <= fwd_data_d;
            data_addr_q      <= data_addr_d;
            data_way_q       <= data_way_d;
            tag_update_way_q <= tag_update_way_d;
            cnt_q            <= cnt_d;
            fill_busy_q      <= fill_busy_d;
            mem_req_q        <= mem_req_d;
            data_we_q        <= data_we_d;
            tag_update_q     <= tag_update_d;
            fwd_valid_q      <= fwd_valid_d;
            flush_done_q     <= flush_done_d;
`ifdef ICACHE_FLUSH_EN
            flush_pend_q     <= flush_pend_d;
`endif
        end
    end

    assign fill_busy      = fill_busy_q;
    assign mem_req        = mem_req_q;
    assign mem_addr       = mem_addr_q;
    assign data_we        = data_we_q;
    assign data_way       = data_way_q;
    assign data_addr      = data_addr_q;
    assign data_wdata     = data_wdata_q;
    assign tag_update     = tag_update_q;
    assign tag_update_way = tag_update_way_q;
    assign fill_addr      = fill_addr_q;
    assign fwd_valid      = fwd_valid_q;
    assign fwd_data       = fwd_data_q;
    assign flush_done     = flush_done_q;
endmodule
